// File: rtl/eth_pcs_params_pkg.sv
// eth_pcs_params: shared 10GBASE-R PCS widths, scrambler taps, sync codes and the
// scrambler step function (also used by the RX descrambler).
package eth_pcs_params;
    localparam int W_DATA          = 32;
    localparam int W_SYNC          = 2;
    localparam int W_TRANS_PER_BLK = 2;
    localparam int W_SCR_STATE     = 58;
    localparam int SCR_TAP_A       = 38;
    localparam int SCR_TAP_B       = 57;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    // S[0] is the newest scrambled bit; the last bit of a word lands in S[0].
    function automatic logic [W_SCR_STATE+W_DATA-1:0] scr_step(
        input logic [W_SCR_STATE-1:0] state,
        input logic [W_DATA-1:0]      data
    );
        logic [W_DATA-1:0]      scr;
        logic [W_SCR_STATE-1:0] nxt;
        nxt = {state[W_SCR_STATE-1-W_DATA:0], {W_DATA{1'b0}}};
        for (int i = 0; i < W_DATA; i++) begin
            scr[i]            = data[i] ^ state[SCR_TAP_A-i] ^ state[SCR_TAP_B-i];
            nxt[W_DATA-1-i]   = scr[i];
        end
        return {nxt, scr};
    endfunction
endpackage

// File: rtl/eth_pcs_tx_scrambler_if.sv
// eth_pcs_tx_scrambler_if: encoder/gearbox-facing signals of the TX scrambler.
// ETH_PCS_TX_SCR_BYPASS_EN adds the i_scr_bypass control.
interface eth_pcs_tx_scrambler_if;
    import eth_pcs_params::*;
    logic                       i_gb_clk_en;
    logic [W_TRANS_PER_BLK-1:0] i_gb_trans_cnt;
    logic                       i_blk_first;
    logic [W_SYNC-1:0]          i_sync_hdr;
    logic [W_DATA-1:0]          i_enc_data;
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
    logic                       i_scr_bypass;
`endif
    logic                       o_enc_ready;
    logic [W_SYNC-1:0]          o_sync_hdr;
    logic [W_DATA-1:0]          o_scr_data;
    logic                       o_align_err;
    logic                       o_hdr_err;

    modport master (
        output i_gb_clk_en, i_gb_trans_cnt, i_blk_first, i_sync_hdr, i_enc_data,
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
        output i_scr_bypass,
`endif
        input  o_enc_ready, o_sync_hdr, o_scr_data, o_align_err, o_hdr_err
    );
    modport slave (
        input  i_gb_clk_en, i_gb_trans_cnt, i_blk_first, i_sync_hdr, i_enc_data,
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
        input  i_scr_bypass,
`endif
        output o_enc_ready, o_sync_hdr, o_scr_data, o_align_err, o_hdr_err
    );
endinterface

// File: rtl/eth_pcs_tx_scrambler.sv
// eth_pcs_tx_scrambler: 10GBASE-R 1+x^39+x^58 payload scrambler paced by the gearbox,
// with block-alignment and sync-header checks. Optional ETH_PCS_TX_SCR_BYPASS_EN.
module eth_pcs_tx_scrambler
    import eth_pcs_params::*;
#(
    parameter logic [W_SCR_STATE-1:0] SCR_SEED = '0
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    eth_pcs_tx_scrambler_if.slave bus
);
    logic [W_SCR_STATE-1:0] r_state;
    logic [W_SCR_STATE-1:0] w_next_state;
    logic [W_DATA-1:0]      w_scr;
    logic                   r_align_err;
    logic                   r_hdr_err;
    logic                   w_accept;
    logic                   w_misalign;
    logic                   w_bad_hdr;

    if (W_DATA > SCR_TAP_A + 1) begin : g_width_chk
        $error("eth_pcs_tx_scrambler: W_DATA must not exceed 39");
    end

    assign {w_next_state, w_scr} = scr_step(r_state, bus.i_enc_data);
    assign w_accept   = bus.i_gb_clk_en;
    assign w_misalign = bus.i_blk_first != (bus.i_gb_trans_cnt == '0);
    assign w_bad_hdr  = bus.i_blk_first && bus.i_sync_hdr != SYNC_DATA && bus.i_sync_hdr != SYNC_CTRL;

    assign bus.o_enc_ready = bus.i_gb_clk_en;
    assign bus.o_sync_hdr  = bus.i_sync_hdr;
    assign bus.o_align_err = r_align_err;
    assign bus.o_hdr_err   = r_hdr_err;
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
    // State still advances under bypass so clearing it resumes a consistent sequence.
    assign bus.o_scr_data  = bus.i_scr_bypass ? bus.i_enc_data : w_scr;
`else
    assign bus.o_scr_data  = w_scr;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= SCR_SEED;
            r_align_err <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            if (w_accept) r_state <= w_next_state;
            r_align_err <= r_align_err | (w_accept & w_misalign);
            r_hdr_err   <= w_accept & w_bad_hdr;
        end
    end
endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// tb_eth_pcs_tx_scrambler: directed vectors with a scoreboard queue; the monitor checks
// exact words, descrambles payload with a serial reference model, and checks flags.
module tb_eth_pcs_tx_scrambler;
    import eth_pcs_params::*;
    localparam logic [57:0] SEED = 58'h40_0000_0000;

    typedef struct {
        logic        en;
        logic        chk;
        logic [31:0] scr;
        logic [31:0] pay;
        logic [1:0]  hdr;
        logic        align;
        logic        herr;
    } item_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checks = 0;
    int    failures = 0;
    item_t sbq[$];

    eth_pcs_tx_scrambler_if bus();

    eth_pcs_tx_scrambler #(.SCR_SEED(SEED)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic en, input logic [1:0] cnt, input logic first, input logic [1:0] hdr,
                        input logic [31:0] data, input logic chk, input logic [31:0] exp_scr,
                        input logic ea, input logic eh);
        item_t it;
        @(posedge clk);
        #1;
        bus.i_gb_clk_en    = en;
        bus.i_gb_trans_cnt = cnt;
        bus.i_blk_first    = first;
        bus.i_sync_hdr     = hdr;
        bus.i_enc_data     = data;
        it = '{en, chk, exp_scr, data, hdr, ea, eh};
        sbq.push_back(it);
    endtask

    // Monitor: serial reference descrambler, h[0] is the newest received bit.
    initial begin
        logic [57:0] h;
        logic [31:0] w;
        logic [31:0] d;
        item_t       it;
        h = SEED;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) h = SEED;
            else if (sbq.size() != 0) begin
                it = sbq.pop_front();
                check("enc_ready", {63'd0, bus.o_enc_ready}, {63'd0, it.en});
                check("sync_hdr", {62'd0, bus.o_sync_hdr}, {62'd0, it.hdr});
                check("align_err", {63'd0, bus.o_align_err}, {63'd0, it.align});
                check("hdr_err", {63'd0, bus.o_hdr_err}, {63'd0, it.herr});
                if (it.en) begin
                    w = bus.o_scr_data;
                    if (it.chk) check("scr_word", {32'd0, w}, {32'd0, it.scr});
                    for (int b = 0; b < 32; b++) begin
                        d[b] = w[b] ^ h[38] ^ h[57];
                        h    = {h[56:0], w[b]};
                    end
                    check("loopback", {32'd0, d}, {32'd0, it.pay});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  hdr;
        logic [31:0] dat;
        rst_n = 1'b0;
        bus.i_gb_clk_en = 1'b0; bus.i_gb_trans_cnt = '0; bus.i_blk_first = 1'b0;
        bus.i_sync_hdr = 2'b01; bus.i_enc_data = '0;
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
        bus.i_scr_bypass = 1'b0;
`endif
        #12;
        check("rst_align", {63'd0, bus.o_align_err}, 64'd0);
        check("rst_hdr_err", {63'd0, bus.o_hdr_err}, 64'd0);
        check("rst_seed_word", {32'd0, bus.o_scr_data}, 64'h0008_0001);
        #10 rst_n = 1'b1;
        // Seed run, then reset and the same with a stall in between.
        xfer(1, 0, 1, 2'b01, 0, 1, 32'h0008_0001, 0, 0);
        xfer(1, 1, 0, 2'b01, 0, 1, 32'h0000_0080, 0, 0);
        @(posedge clk); #1 bus.i_gb_clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        xfer(1, 0, 1, 2'b01, 0, 1, 32'h0008_0001, 0, 0);
        xfer(0, 1, 0, 2'b01, 32'hDEAD_BEEF, 0, 0, 0, 0);
        xfer(1, 1, 0, 2'b01, 0, 1, 32'h0000_0080, 0, 0);
        // Random loopback blocks with occasional stalls.
        for (int k = 0; k < 1000; k++) begin
            hdr = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            xfer(1, 0, 1, hdr, $urandom, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) xfer(0, 1, 0, hdr, $urandom, 0, 0, 0, 0);
            xfer(1, 1, 0, hdr, $urandom, 0, 0, 0, 0);
        end
        // Header pulses: back-to-back, stall gap, legal codes silent.
        xfer(1, 0, 1, 2'b00, $urandom, 0, 0, 0, 0);
        xfer(1, 0, 1, 2'b11, $urandom, 0, 0, 0, 1);
        xfer(0, 0, 1, 2'b11, $urandom, 0, 0, 0, 1);
        xfer(1, 1, 0, 2'b11, $urandom, 0, 0, 0, 0);
        xfer(1, 0, 1, 2'b01, $urandom, 0, 0, 0, 0);
        xfer(1, 1, 0, 2'b10, $urandom, 0, 0, 0, 0);
        xfer(1, 0, 1, 2'b10, $urandom, 0, 0, 0, 0);
        xfer(0, 1, 1, 2'b01, $urandom, 0, 0, 0, 0);
        // Alignment: misaligned first on an accepted cycle becomes sticky.
        xfer(1, 1, 1, 2'b01, $urandom, 0, 0, 0, 0);
        xfer(0, 0, 0, 2'b01, $urandom, 0, 0, 1, 0);
        xfer(1, 0, 1, 2'b01, $urandom, 0, 0, 1, 0);
        xfer(1, 1, 0, 2'b01, $urandom, 0, 0, 1, 0);
        // Asynchronous reset between edges, mid-block.
        @(posedge clk);
        #1 bus.i_gb_clk_en = 1'b0; bus.i_enc_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async_align", {63'd0, bus.o_align_err}, 64'd0);
        check("async_hdr_err", {63'd0, bus.o_hdr_err}, 64'd0);
        check("async_seed_word", {32'd0, bus.o_scr_data}, 64'h0008_0001);
        @(posedge clk);
        #3 rst_n = 1'b1;
        xfer(1, 0, 1, 2'b01, 0, 1, 32'h0008_0001, 0, 0);
        xfer(1, 1, 0, 2'b01, 0, 1, 32'h0000_0080, 0, 0);
        xfer(1, 0, 0, 2'b01, $urandom, 0, 0, 0, 0);
        dat = $urandom;
        xfer(1, 1, 0, 2'b01, dat, 0, 0, 1, 0);
        @(posedge clk);
        #1 bus.i_gb_clk_en = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eth_pcs_tx_scrambler.md
Name: eth_pcs_tx_scrambler

Overview:
- Upstream neighbour of the TX gearbox.
- Applies the 10GBASE-R self-synchronous scrambler (G(x)=1+x^39+x^58) to the 64b/66b payload, which arrives from the encoder in W_DATA-bit transfers.
- Passes the 2-bit sync header through unscrambled.
- Paced entirely by the gearbox's clk_en/trans_cnt. Also checks encoder block alignment and sync-header legality.

Parameters:
- SCR_SEED, 58'h0, initial scrambler state loaded on reset.
- W_DATA, W_SYNC, W_TRANS_PER_BLK: taken from eth_pcs_params, not overridable.

Ports:
- i_clk  in  1  PCS TX clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_gb_clk_en  in  1  gearbox accepts a transfer this cycle
- i_gb_trans_cnt  in  W_TRANS_PER_BLK  gearbox transfer index within the block
- i_blk_first  in  1  encoder marks the first transfer of a block
- i_sync_hdr  in  W_SYNC  encoder sync header, valid with i_blk_first
- i_enc_data  in  W_DATA  encoded payload transfer, bit 0 transmitted first
- o_enc_ready  out  1  encoder may advance; equals i_gb_clk_en
- o_sync_hdr  out  W_SYNC  header to gearbox, equals i_sync_hdr
- o_scr_data  out  W_DATA  scrambled payload to gearbox
- o_align_err  out  1  sticky: i_blk_first disagreed with i_gb_trans_cnt
- o_hdr_err  out  1  one-cycle pulse: illegal header (2'b00/2'b11) accepted

Behaviour:
- State: S[57:0]; S[0] is the most recently scrambled bit. Reset (asynchronous) loads SCR_SEED. o_align_err=0, o_hdr_err=0.
- Datapath: o_scr_data is combinational from S and i_enc_data, with zero latency. The gearbox samples it in the same cycle it asserts clk_en.
- Scramble rule, for each bit i in 0..W_DATA-1:
  - out[i] = d[i] ^ S[38-i] ^ S[57-i].
  - Requires W_DATA <= 39. An elaboration-time assertion enforces this.
- State update on the rising edge when i_gb_clk_en=1:
  - S_new[W_DATA-1-i] = out[i]
  - S_new[57:W_DATA] = S[57-W_DATA:0]
- i_gb_clk_en=0 (gearbox stall cycle): S holds. Outputs still toggle combinationally, but the gearbox ignores them. o_enc_ready=0, so the encoder holds its data.
- Header: o_sync_hdr = i_sync_hdr, never scrambled. The gearbox uses it only when trans_cnt==0.
- Alignment check, on accepted cycles only: if i_blk_first != (i_gb_trans_cnt==0), o_align_err is set on the next edge. It clears only on reset. Scrambling is unaffected.
- Header check: on an accepted cycle with i_blk_first=1 and i_sync_hdr in {2'b00, 2'b11}, o_hdr_err=1 on the following cycle only.
  - Back-to-back bad headers give back-to-back pulses.
  - A stall cycle between them produces no pulse for the stall cycle.
- Reset mid-block: S returns to SCR_SEED immediately and both error flags clear. The first accepted transfer after reset release is scrambled with SCR_SEED.

Optional Feature:
- Macro: ETH_PCS_TX_SCR_BYPASS_EN.
- Defined:
  - Adds input i_scr_bypass (1).
  - While it is high, o_scr_data = i_enc_data.
  - S keeps advancing on accepted cycles using the computed scrambled bits, so clearing bypass resumes a consistent sequence.
- Undefined: port is absent and scrambling is always on.

Decomposition:
- eth_pcs_params gains:
  - W_SCR_STATE=58, SCR_TAP_A=38, SCR_TAP_B=57
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - function scr_step(state, data) returning {next_state, scrambled}, reusable by the RX descrambler.
- No sub-module. Scrambler core, alignment checker and header checker all stay in this module.

Test Plan:
- Reset then run: SCR_SEED=58'h40_0000_0000 (S[38]=1), i_enc_data=0 on two accepted cycles -> o_scr_data=32'h0008_0001, then 32'h0000_0080.
- Stall transparency: insert i_gb_clk_en=0 between those two transfers -> second accepted word is still 32'h0000_0080. o_enc_ready=0 during the stall.
- Loopback: 1000 random blocks scrambled, then fed through a reference descrambler -> payload matches bit-exactly. o_sync_hdr equals input every cycle.
- Alignment: assert i_blk_first while i_gb_trans_cnt=1 -> o_align_err=1 from the next edge and remains 1 until i_reset_n=0.
- Header: accept i_sync_hdr=2'b11 with i_blk_first=1 -> o_hdr_err=1 for exactly one cycle. 2'b01 and 2'b10 never pulse.
- Async reset mid-block: drop i_reset_n between edges -> S=SCR_SEED and flags=0 immediately. The first test's vector sequence repeats after release.
